l1_icache_assoc: RTL and testbench

Parametrised, set-associative L1 instruction cache with a blocking miss-refill engine.

- Front side: a handshaked fetch read port and a loader write port.
- Back side: a single-word request/acknowledge refill interface to the next level (L2 or memory).
- Adds over the single-set, write-then-read L1 instruction cache: configurable sets and ways, automatic refill, round-robin replacement, whole-cache flush and saturating hit/miss counters.

---
 rtl/l1_cache_pkg.sv | 19 +
 rtl/l1_icache_assoc_if.sv | 37 +++
 rtl/l1_cache_way.sv | 50 +++++
 rtl/l1_icache_assoc.sv | 161 ++++++++++++++++
 tb/tb_l1_icache_assoc.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/l1_cache_pkg.sv
// Shared types and geometry helpers for the set-associative L1 instruction cache.
package l1_cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RESP_HIT,
        REFILL,
        RESP_MISS
    } cacheState_t;

    function automatic int unsigned idxW(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tagW(input int unsigned addrW, input int unsigned sets);
        return addrW - $clog2(sets);
    endfunction

endpackage

// File: rtl/l1_icache_assoc_if.sv
// Fetch, loader, refill and counter signals of the L1 instruction cache.
interface l1_icache_assoc_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 16
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_hit;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_hit;
    logic              flush;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_data;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    modport slave (
        input  rd_req, rd_addr, wr_en, wr_addr, wr_data, flush, mem_ack, mem_data,
        output rd_ready, rd_valid, rd_data, rd_hit, wr_hit, mem_req, mem_addr,
               hit_count, miss_count
    );

    modport master (
        output rd_req, rd_addr, wr_en, wr_addr, wr_data, flush, mem_ack, mem_data,
        input  rd_ready, rd_valid, rd_data, rd_hit, wr_hit, mem_req, mem_addr,
               hit_count, miss_count
    );

endinterface

// File: rtl/l1_cache_way.sv
// One cache way: valid/tag/data for every set, a fetch lookup, a loader probe and one write port.
module l1_cache_way
    import l1_cache_pkg::*;
#(
    parameter int unsigned SETS   = 4,
    parameter int unsigned TAG_W  = 14,
    parameter int unsigned DATA_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [idxW(SETS)-1:0]   lookupIdx,
    input  logic [TAG_W-1:0]        lookupTag,
    output logic                    lookupValid,
    output logic                    lookupHit,
    output logic [DATA_W-1:0]       lookupData,
    input  logic [idxW(SETS)-1:0]   probeIdx,
    input  logic [TAG_W-1:0]        probeTag,
    output logic                    probeHit,
    input  logic                    wrEn,
    input  logic [idxW(SETS)-1:0]   wrIdx,
    input  logic [TAG_W-1:0]        wrTag,
    input  logic [DATA_W-1:0]       wrData,
    input  logic                    flushClr
);
    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tags [SETS];
    logic [DATA_W-1:0] data [SETS];

    assign lookupValid = valid[lookupIdx];
    assign lookupHit   = valid[lookupIdx] && (tags[lookupIdx] == lookupTag);
    assign lookupData  = data[lookupIdx];
    assign probeHit    = valid[probeIdx] && (tags[probeIdx] == probeTag);

    // Flush wins over any write landing in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || flushClr) begin
            valid <= '0;
        end else if (wrEn) begin
            valid[wrIdx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn && !flushClr) begin
            tags[wrIdx] <= wrTag;
            data[wrIdx] <= wrData;
        end
    end

endmodule

// File: rtl/l1_icache_assoc.sv
// Set-associative L1 instruction cache: blocking refill FSM, round-robin victims, flush, saturating counters.
module l1_icache_assoc
    import l1_cache_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SETS   = 4,
    parameter int unsigned WAYS   = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    l1_icache_assoc_if.slave bus
);
    localparam int unsigned IDX_W = idxW(SETS);
    localparam int unsigned TAG_W = tagW(ADDR_W, SETS);
    localparam int unsigned PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    cacheState_t       state, nextState;
    logic [ADDR_W-1:0] reqAddr;
    logic [ADDR_W-1:0] lookupAddr;
    logic [IDX_W-1:0]  reqIdx;
    logic [PTR_W-1:0]  ptr [SETS];
    logic [PTR_W-1:0]  victim;
    logic              victimFound;
    logic [WAYS-1:0]   wayValid;
    logic [WAYS-1:0]   wayHit;
    logic [WAYS-1:0]   probeHit;
    logic [DATA_W-1:0] wayData [WAYS];
    logic              anyHit;
    logic [DATA_W-1:0] hitData;
    logic              accept;
    logic              fill;
    logic              installEn;
    logic              flushSeen;
    logic [DATA_W-1:0] fillWord;
    logic              rdValid;
    logic              rdHit;
    logic              wrHit;
    logic [DATA_W-1:0] rdData;
    logic [CNT_W-1:0]  hitCnt;
    logic [CNT_W-1:0]  missCnt;

    assign accept     = bus.rd_ready && bus.rd_req;
    assign lookupAddr = (state == IDLE) ? bus.rd_addr : reqAddr;
    assign reqIdx     = reqAddr[IDX_W-1:0];
    assign fill       = (state == REFILL) && bus.mem_ack;
    assign fillWord   = (bus.wr_en && (bus.wr_addr == reqAddr)) ? bus.wr_data : bus.mem_data;
    // A flush seen at any point of the refill suppresses the install.
    assign installEn  = fill && !flushSeen && !bus.flush;

    for (genvar w = 0; w < WAYS; w++) begin : gWay
        logic install;
        logic wayWr;
        // The install owns the single write port of its way in the fill cycle.
        assign install = installEn && (victim == PTR_W'(w));
        assign wayWr   = install || (bus.wr_en && probeHit[w]);

        l1_cache_way #(
            .SETS   (SETS),
            .TAG_W  (TAG_W),
            .DATA_W (DATA_W)
        ) uWay (
            .clk         (clk),
            .rst_n       (rst_n),
            .lookupIdx   (lookupAddr[IDX_W-1:0]),
            .lookupTag   (lookupAddr[ADDR_W-1:IDX_W]),
            .lookupValid (wayValid[w]),
            .lookupHit   (wayHit[w]),
            .lookupData  (wayData[w]),
            .probeIdx    (bus.wr_addr[IDX_W-1:0]),
            .probeTag    (bus.wr_addr[ADDR_W-1:IDX_W]),
            .probeHit    (probeHit[w]),
            .wrEn        (wayWr),
            .wrIdx       (install ? reqIdx : bus.wr_addr[IDX_W-1:0]),
            .wrTag       (install ? reqAddr[ADDR_W-1:IDX_W] : bus.wr_addr[ADDR_W-1:IDX_W]),
            .wrData      (install ? fillWord : bus.wr_data),
            .flushClr    (bus.flush)
        );
    end

    always_comb begin
        anyHit  = 1'b0;
        hitData = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (wayHit[w]) begin
                anyHit  = 1'b1;
                hitData = wayData[w];
            end
        end
    end

    always_comb begin
        victim      = ptr[reqIdx];
        victimFound = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!victimFound && !wayValid[w]) begin
                victim      = PTR_W'(w);
                victimFound = 1'b1;
            end
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:      if (accept) nextState = anyHit ? RESP_HIT : REFILL;
            RESP_HIT:  nextState = IDLE;
            REFILL:    if (bus.mem_ack) nextState = RESP_MISS;
            RESP_MISS: nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reqAddr   <= '0;
            rdData    <= '0;
            rdValid   <= 1'b0;
            rdHit     <= 1'b0;
            wrHit     <= 1'b0;
            flushSeen <= 1'b0;
            hitCnt    <= '0;
            missCnt   <= '0;
        end else begin
            rdValid   <= (nextState == RESP_HIT) || (nextState == RESP_MISS);
            rdHit     <= (nextState == RESP_HIT);
            wrHit     <= bus.wr_en && (|probeHit);
            flushSeen <= (state == REFILL) && !bus.mem_ack && (flushSeen || bus.flush);
            if (accept) reqAddr <= bus.rd_addr;
            if (accept && anyHit) rdData <= hitData;
            if (fill) rdData <= fillWord;
            if ((state == RESP_HIT) && (hitCnt != '1)) hitCnt <= hitCnt + CNT_W'(1);
            if ((state == RESP_MISS) && (missCnt != '1)) missCnt <= missCnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            for (int unsigned s = 0; s < SETS; s++) ptr[s] <= '0;
        end else if (installEn) begin
            ptr[reqIdx] <= (WAYS == 1) ? '0 : ptr[reqIdx] + PTR_W'(1);
        end
    end

    assign bus.rd_ready   = (state == IDLE) && rst_n;
    assign bus.rd_valid   = rdValid;
    assign bus.rd_hit     = rdHit;
    assign bus.rd_data    = rdData;
    assign bus.wr_hit     = wrHit;
    assign bus.mem_req    = (state == REFILL);
    assign bus.mem_addr   = reqAddr;
    assign bus.hit_count  = hitCnt;
    assign bus.miss_count = missCnt;

endmodule

// File: tb/tb_l1_icache_assoc.sv
// Directed bench for l1_icache_assoc: 2-way, 4-set, 4-bit counters, memory returns addr+100 after 3 cycles.
module tb_l1_icache_assoc;

    logic clk;
    logic rst_n;
    logic memAuto;
    logic autoAck;
    logic manualAck;
    int unsigned memWait;
    int unsigned testCount;
    int unsigned failCount;

    l1_icache_assoc_if #(.ADDR_W(16), .DATA_W(16), .CNT_W(4)) bus ();

    l1_icache_assoc #(
        .ADDR_W (16),
        .DATA_W (16),
        .SETS   (4),
        .WAYS   (2),
        .CNT_W  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: ack in the third cycle of a request, data = address + 100.
    assign bus.mem_data = bus.mem_addr + 16'd100;
    assign bus.mem_ack  = autoAck | manualAck;

    always @(negedge clk) begin
        if (bus.mem_req && memAuto) begin
            memWait = memWait + 1;
            autoAck = (memWait == 3);
        end else begin
            memWait = 0;
            autoAck = 1'b0;
        end
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic doRead(input string tag, input logic [15:0] addr, input logic expHit,
                          input logic [15:0] expData, input logic flushAt);
        int unsigned n;
        logic        sawReq;
        logic [15:0] reqA;
        bus.rd_req  = 1'b1;
        bus.rd_addr = addr;
        @(negedge clk);
        bus.rd_req = 1'b0;
        checkEq($sformatf("%s.busy", tag), bus.rd_ready, 0);
        n      = 1;
        sawReq = 1'b0;
        reqA   = '0;
        while (!bus.rd_valid && n < 20) begin
            if (bus.mem_req && !sawReq) begin
                sawReq = 1'b1;
                reqA   = bus.mem_addr;
            end
            bus.flush = flushAt && (n == 1);
            @(negedge clk);
            n++;
        end
        bus.flush = 1'b0;
        checkEq($sformatf("%s.valid", tag), bus.rd_valid, 1);
        checkEq($sformatf("%s.hit", tag), bus.rd_hit, expHit);
        checkEq($sformatf("%s.data", tag), bus.rd_data, expData);
        checkEq($sformatf("%s.latency", tag), n, expHit ? 1 : 4);
        checkEq($sformatf("%s.memreq", tag), sawReq, !expHit);
        if (sawReq) checkEq($sformatf("%s.memaddr", tag), reqA, addr);
        @(negedge clk);
        checkEq($sformatf("%s.ready", tag), bus.rd_ready, 1);
        checkEq($sformatf("%s.pulse", tag), bus.rd_valid, 0);
    endtask

    task automatic doWrite(input string tag, input logic [15:0] addr, input logic [15:0] data,
                           input logic expHit);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_en = 1'b0;
        checkEq($sformatf("%s.wrhit", tag), bus.wr_hit, expHit);
    endtask

    initial begin
        testCount   = 0;
        failCount   = 0;
        memWait     = 0;
        autoAck     = 1'b0;
        manualAck   = 1'b0;
        memAuto     = 1'b1;
        rst_n       = 1'b0;
        bus.rd_req  = 1'b0;
        bus.rd_addr = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.flush   = 1'b0;

        repeat (3) @(negedge clk);
        checkEq("rst.ready", bus.rd_ready, 0);
        checkEq("rst.valid", bus.rd_valid, 0);
        checkEq("rst.rdhit", bus.rd_hit, 0);
        checkEq("rst.wrhit", bus.wr_hit, 0);
        checkEq("rst.memreq", bus.mem_req, 0);
        checkEq("rst.rddata", bus.rd_data, 0);
        checkEq("rst.memaddr", bus.mem_addr, 0);
        checkEq("rst.hits", bus.hit_count, 0);
        checkEq("rst.misses", bus.miss_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkEq("idle.ready", bus.rd_ready, 1);

        doRead("cold0", 16'd0, 1'b0, 16'd100, 1'b0);
        checkEq("cold0.misses", bus.miss_count, 1);
        doRead("hit0", 16'd0, 1'b1, 16'd100, 1'b0);
        checkEq("hit0.hits", bus.hit_count, 1);

        doWrite("wr0", 16'd0, 16'd23, 1'b1);
        doRead("rdw0", 16'd0, 1'b1, 16'd23, 1'b0);
        doWrite("wr1", 16'd1, 16'd42, 1'b0);
        doRead("rd1", 16'd1, 1'b0, 16'd101, 1'b0);

        doRead("rd8", 16'd8, 1'b0, 16'd108, 1'b0);
        doRead("keep0", 16'd0, 1'b1, 16'd23, 1'b0);
        doRead("rd16", 16'd16, 1'b0, 16'd116, 1'b0);
        doRead("evict0", 16'd0, 1'b0, 16'd100, 1'b0);
        doRead("evict8", 16'd8, 1'b0, 16'd108, 1'b0);
        checkEq("evict.misses", bus.miss_count, 6);
        checkEq("evict.hits", bus.hit_count, 3);

        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        doRead("flush0", 16'd0, 1'b0, 16'd100, 1'b0);
        doRead("flushfill", 16'd2, 1'b0, 16'd102, 1'b1);
        doRead("notinst", 16'd2, 1'b0, 16'd102, 1'b0);

        // Loader write to the refill address in the ack cycle replaces the fill word.
        memAuto     = 1'b0;
        bus.rd_req  = 1'b1;
        bus.rd_addr = 16'd3;
        @(negedge clk);
        bus.rd_req = 1'b0;
        checkEq("wrfill.memreq", bus.mem_req, 1);
        checkEq("wrfill.memaddr", bus.mem_addr, 3);
        @(negedge clk);
        manualAck   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 16'd3;
        bus.wr_data = 16'd55;
        @(negedge clk);
        manualAck = 1'b0;
        bus.wr_en = 1'b0;
        checkEq("wrfill.valid", bus.rd_valid, 1);
        checkEq("wrfill.hit", bus.rd_hit, 0);
        checkEq("wrfill.data", bus.rd_data, 55);
        checkEq("wrfill.memdrop", bus.mem_req, 0);
        checkEq("wrfill.wrhit", bus.wr_hit, 0);
        memAuto = 1'b1;
        @(negedge clk);
        doRead("wrfill.reread", 16'd3, 1'b1, 16'd55, 1'b0);
        checkEq("pre.hits", bus.hit_count, 4);
        checkEq("pre.misses", bus.miss_count, 10);

        for (int i = 0; i < 20; i++) doRead($sformatf("sat%0d", i), 16'd3, 1'b1, 16'd55, 1'b0);
        checkEq("sat.hits", bus.hit_count, 15);
        checkEq("sat.misses", bus.miss_count, 10);

        bus.rd_req  = 1'b1;
        bus.rd_addr = 16'd5;
        @(negedge clk);
        bus.rd_req = 1'b0;
        checkEq("rstfill.memreq", bus.mem_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        checkEq("rstfill.drop", bus.mem_req, 0);
        checkEq("rstfill.hits", bus.hit_count, 0);
        checkEq("rstfill.misses", bus.miss_count, 0);
        checkEq("rstfill.ready", bus.rd_ready, 0);
        rst_n     = 1'b1;
        manualAck = 1'b1;
        @(negedge clk);
        manualAck = 1'b0;
        checkEq("lateack.memreq", bus.mem_req, 0);
        checkEq("lateack.valid", bus.rd_valid, 0);
        checkEq("lateack.ready", bus.rd_ready, 1);
        @(negedge clk);
        checkEq("lateack.novalid", bus.rd_valid, 0);
        doRead("postrst1", 16'd1, 1'b0, 16'd101, 1'b0);
        checkEq("postrst.misses", bus.miss_count, 1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
